nn_out_reader: RTL and testbench

NN_OUT_READER -- requirements
Module: nn_out_reader

---
 rtl/nn_out_reader.sv | 145 ++++++++++++++
 tb/tb_nn_out_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nn_out_reader.sv
// Captures two 384-bit convolution result vectors and streams their 64 elements
// over a valid/ready port. Optional argmax tracking is enabled by NN_RD_ARGMAX_EN.
module nn_out_reader #(
   parameter int ELEM_W = 12,
   parameter int N_ELEM = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ELEM_W*N_ELEM-1:0]   out1,
   input  logic [ELEM_W*N_ELEM-1:0]   out2,
   output logic                       busy,
   output logic [ELEM_W-1:0]          dout,
   output logic [5:0]                 dout_idx,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       dout_last,
   output logic                       done,
   output logic [ELEM_W-1:0]          max_val,
   output logic [5:0]                 max_idx
);

   localparam int         BUF_W    = 2 * ELEM_W * N_ELEM;
   localparam logic [5:0] LAST_IDX = 6'(2 * N_ELEM - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [5:0]         idx_q, idx_d;
   logic               capture;
   logic               xfer;
   logic               is_last;
   logic [ELEM_W-1:0]  elem;

   assign is_last = (idx_q == LAST_IDX);
   assign elem    = buf_q[int'(idx_q) * ELEM_W +: ELEM_W];
   assign xfer    = (state_q == SEND) && dout_ready;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               buf_d   = {out2, out1};
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               // Index 63 is terminal: leave it there rather than wrapping.
               if (is_last) state_d = DONE;
               else         idx_d   = idx_q + 6'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: the capture buffer is deliberately left out of reset; its contents
   // are only read in SEND, which can only be reached through a fresh capture.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign busy       = (state_q != IDLE);
   assign dout_valid = (state_q == SEND);
   assign dout       = dout_valid ? elem : '0;
   assign dout_idx   = idx_q;
   assign dout_last  = dout_valid && is_last;
   assign done       = (state_q == DONE);

`ifdef NN_RD_ARGMAX_EN
   logic [ELEM_W-1:0] run_val_q, run_val_d;
   logic [5:0]        run_idx_q, run_idx_d;
   logic [ELEM_W-1:0] max_val_q, max_val_d;
   logic [5:0]        max_idx_q, max_idx_d;

   always_comb begin
      run_val_d = run_val_q;
      run_idx_d = run_idx_q;
      max_val_d = max_val_q;
      max_idx_d = max_idx_q;
      if (capture) begin
         run_val_d = '0;
         run_idx_d = '0;
      end else if (xfer) begin
         // Strictly greater only, so a tie keeps the earlier (lower) index.
         if (elem > run_val_q) begin
            run_val_d = elem;
            run_idx_d = idx_q;
         end
         if (is_last) begin
            max_val_d = run_val_d;
            max_idx_d = run_idx_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_val_q <= '0;
         run_idx_q <= '0;
         max_val_q <= '0;
         max_idx_q <= '0;
      end else begin
         run_val_q <= run_val_d;
         run_idx_q <= run_idx_d;
         max_val_q <= max_val_d;
         max_idx_q <= max_idx_d;
      end
   end

   assign max_val = max_val_q;
   assign max_idx = max_idx_q;
`else
   assign max_val = '0;
   assign max_idx = '0;
`endif

endmodule

// File: tb/tb_nn_out_reader.sv
// Directed bench for nn_out_reader: streaming order, backpressure, ignored start,
// mid-frame reset, start held through DONE and argmax results (either build).
module tb_nn_out_reader;

   localparam int ELEM_W = 12;
   localparam int N_ELEM = 32;

`ifdef NN_RD_ARGMAX_EN
   localparam bit AM = 1'b1;
`else
   localparam bit AM = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic [ELEM_W*N_ELEM-1:0] out1;
   logic [ELEM_W*N_ELEM-1:0] out2;
   logic                     busy;
   logic [ELEM_W-1:0]        dout;
   logic [5:0]               dout_idx;
   logic                     dout_valid;
   logic                     dout_ready;
   logic                     dout_last;
   logic                     done;
   logic [ELEM_W-1:0]        max_val;
   logic [5:0]               max_idx;

   int n_vec  = 0;
   int n_miss = 0;
   int exp_e [64];

   nn_out_reader #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .out1       (out1),
      .out2       (out2),
      .busy       (busy),
      .dout       (dout),
      .dout_idx   (dout_idx),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .done       (done),
      .max_val    (max_val),
      .max_idx    (max_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: out1[k]=k, out2[k]=100+k; mode 1: 3k / 200+k; mode 2: argmax tie pattern
   task automatic load_vectors(input int mode);
      int a, b;
      for (int k = 0; k < N_ELEM; k++) begin
         case (mode)
            0: begin a = k;     b = 100 + k; end
            1: begin a = 3 * k; b = 200 + k; end
            default: begin
               a = (k == 5) ? 'hABC : k;
               b = (k == 7) ? 'hABC : k;
            end
         endcase
         out1[k*ELEM_W +: ELEM_W] = 12'(a);
         out2[k*ELEM_W +: ELEM_W] = 12'(b);
         exp_e[k]          = a;
         exp_e[N_ELEM + k] = b;
      end
   endtask

   // Entered one cycle after start was sampled; streams a whole frame (or aborts).
   task automatic stream(input logic [3:0] pat, input int poke_at, input int rst_at,
                         input bit hold, input int mv, input int mi);
      int e   = 0;
      int cyc = 0;
      bit x;
      while (e < 64 && cyc < 400) begin
         dout_ready = pat[cyc % 4];
         start      = hold || (e == poke_at);
         if (e == poke_at) out1 = '1;
         if (e == rst_at) begin
            rst = 1'b1;
            step();
            rst   = 1'b0;
            start = 1'b0;
            check("abort_valid", 32'(dout_valid), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            check("abort_idx", 32'(dout_idx), 0);
            check("abort_max_val", 32'(max_val), 0);
            for (int i = 0; i < 3; i++) begin
               step();
               check("abort_no_done", 32'(done), 0);
            end
            return;
         end
         check("valid", 32'(dout_valid), 1);
         check("dout", 32'(dout), 32'(exp_e[e]));
         check("dout_idx", 32'(dout_idx), 32'(e));
         check("dout_last", 32'(dout_last), 32'(e == 63));
         x = dout_ready;
         step();
         cyc++;
         if (x) e++;
      end
      check("frame_complete", 32'(e), 64);
      check("done", 32'(done), 1);
      check("busy_in_done", 32'(busy), 1);
      check("valid_in_done", 32'(dout_valid), 0);
      check("max_val", 32'(max_val), AM ? 32'(mv) : 0);
      check("max_idx", 32'(max_idx), AM ? 32'(mi) : 0);
      if (!hold) start = 1'b0;
      step();
      check("done_one_cycle", 32'(done), 0);
      check("idle_after_done", 32'(busy), 0);
      check("max_val_held", 32'(max_val), AM ? 32'(mv) : 0);
      check("max_idx_held", 32'(max_idx), AM ? 32'(mi) : 0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      dout_ready = 1'b0;
      out1       = '0;
      out2       = '0;
      step();
      step();
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(dout_valid), 0);
      check("rst_dout", 32'(dout), 0);
      check("rst_idx", 32'(dout_idx), 0);
      check("rst_last", 32'(dout_last), 0);
      check("rst_done", 32'(done), 0);
      check("rst_max_val", 32'(max_val), 0);
      check("rst_max_idx", 32'(max_idx), 0);

      // Reset wins over a simultaneous start.
      start = 1'b1;
      step();
      check("rst_over_start", 32'(busy), 0);
      rst   = 1'b0;
      start = 1'b0;
      step();

      // Frame A: ready held high; inputs scrambled right after capture.
      load_vectors(0);
      start = 1'b1;
      step();
      start = 1'b0;
      out1  = '1;
      out2  = '0;
      stream(4'b1111, -1, -1, 1'b0, 131, 63);

      // Frame B: ready pattern 1,0,0,1 and a stray start with new out1 at idx 10.
      load_vectors(1);
      start = 1'b1;
      step();
      start = 1'b0;
      stream(4'b1001, 10, -1, 1'b0, 231, 63);

      // Frame C: reset at idx 20 aborts without done.
      load_vectors(0);
      start = 1'b1;
      step();
      start = 1'b0;
      stream(4'b1111, -1, 20, 1'b0, 0, 0);

      // Frame D: argmax tie; start held high through DONE begins the next frame.
      load_vectors(2);
      start = 1'b1;
      step();
      stream(4'b1111, -1, -1, 1'b1, 'hABC, 5);
      step();
      check("restart_valid", 32'(dout_valid), 1);
      check("restart_idx", 32'(dout_idx), 0);
      start = 1'b0;
      stream(4'b1111, -1, -1, 1'b0, 'hABC, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
